// File: rtl/mc_control_unit.sv
// mc_control_unit
//   Multi-cycle MIPS control FSM for a shared-memory datapath with IR, A/B,
//   ALUOut and MDR registers. It sequences FETCH/DECODE/EXEC/MEM/WB for
//   R-type, lw, sw, beq, and optionally addi and j. Memory states can stall
//   on a ready handshake from variable-latency memory. The ALU-select decode
//   is folded in: ADD=0, SUB=2, R-type=funct[ALU_S_W-1:0].
//
// Parameters
//   ALU_S_W   width of alu_s
//   HAS_ADDI  1: opcode 8 (addi) legal, 0: illegal
//   HAS_JUMP  1: opcode 2 (j) legal, 0: illegal
//   MEM_WAIT  1: memory states wait for mem_ready, 0: mem_ready treated as 1
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   opcode, funct        IR[31:26], IR[5:0]; opcode valid from DECODE onward
//   mem_ready            memory completes current access this cycle
//   mem_read/mem_write   memory strobes
//   iord                 address mux (0=PC, 1=ALUOut)
//   ir_write             load IR/MDR
//   pc_write             unconditional PC load
//   pc_write_cond        PC load on ALU zero
//   pc_src               0=ALU, 1=ALUOut, 2=jump target
//   alu_src_a            0=PC, 1=A
//   alu_src_b            0=B, 1=4, 2=sext imm, 3=sext imm<<2
//   alu_s                ALU operation select
//   reg_write/reg_dst    register write enable, 0=rt 1=rd
//   mem_to_reg           0=ALUOut, 1=MDR
//   instr_done           pulse in last cycle of each legal instruction
//   illegal_op           pulse in DECODE on unsupported opcode
//   state                current state (debug)
module mc_control_unit #(
  parameter int ALU_S_W  = 3,
  parameter bit HAS_ADDI = 1'b1,
  parameter bit HAS_JUMP = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALU_S_W-1:0] alu_s,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [ALU_S_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_S_W-1:0] ALU_SUB = ALU_S_W'(2);

  state_t r_state;
  state_t w_next;
  logic   w_rdy;
  logic   w_unused_funct;

  // With MEM_WAIT=0 every memory access is assumed to finish in one cycle.
  assign w_rdy          = MEM_WAIT ? mem_ready : 1'b1;
  assign w_unused_funct = ^funct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Reset is also applied combinationally so that write enables drop in the
  // same cycle rst rises, not at the next clock edge.
  assign state = rst ? 4'd0 : r_state;

  always_comb begin
    w_next        = S_FETCH;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_s         = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          // PC+4 is committed only on the ready cycle so it happens once.
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = w_rdy;
          pc_write  = w_rdy;
          w_next    = w_rdy ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          alu_src_b = 2'd3;
          case (opcode)
            OP_RTYPE:     w_next = S_EXEC;
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_BEQ:       w_next = S_BRANCH;
            OP_ADDI: begin
              if (HAS_ADDI) w_next = S_ADDIEX;
              else          illegal_op = 1'b1;
            end
            OP_J: begin
              if (HAS_JUMP) w_next = S_JUMP;
              else          illegal_op = 1'b1;
            end
            default:      illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          w_next    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          w_next   = w_rdy ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = w_rdy;
          w_next     = w_rdy ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_s     = funct[ALU_S_W-1:0];
          w_next    = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_s         = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'd1;
          instr_done    = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          w_next    = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule
